alu_unit_mc: RTL and testbench

- Parametrised, registered ALU-control-plus-execute unit for the multi-cycle MIPS-lite datapath.
- Fully decodes aluop/funct into the existing 3-bit ALU control encoding and executes single-cycle ops with one-cycle latency.
- Adds iterative signed/unsigned multiply into HI/LO, plus mfhi/mflo, behind a valid/ready/done handshake.

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_dec.sv | 38 +++
 rtl/alu_unit_mc.sv | 177 +++++++++++++++++
 tb/tb_alu_unit_mc.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared codes, state and op enums for the ALU control/execute unit
package alu_pkg;

  // decoded ALU control codes reported on gout
  localparam logic [2:0] GOUT_ADD  = 3'b010;
  localparam logic [2:0] GOUT_SUB  = 3'b110;
  localparam logic [2:0] GOUT_SLT  = 3'b111;
  localparam logic [2:0] GOUT_OR   = 3'b001;
  localparam logic [2:0] GOUT_AND  = 3'b000;
  localparam logic [2:0] GOUT_NOR  = 3'b011;
  localparam logic [2:0] GOUT_MISC = 3'b100;

  // R-type function field values
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  // aluop values driven by the main control FSM
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_RT  = 2'b10;
  localparam logic [1:0] ALUOP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_FIX,
    ST_DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_NOR,
    OP_SLT,
    OP_MULT,
    OP_MULTU,
    OP_MFHI,
    OP_MFLO,
    OP_ILL
  } op_e;

endpackage

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - full aluop/funct decode into op kind and 3-bit ALU control
module alu_dec
  import alu_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  input  logic       mul_en_i,
  output op_e        op_o,
  output logic [2:0] gout_o
);

  // exact-match decode; anything unlisted (or multiply ops when disabled) is illegal
  always_comb begin
    op_o   = OP_ILL;
    gout_o = GOUT_MISC;
    case (aluop_i)
      ALUOP_ADD: begin op_o = OP_ADD; gout_o = GOUT_ADD; end
      ALUOP_SUB: begin op_o = OP_SUB; gout_o = GOUT_SUB; end
      ALUOP_OR:  begin op_o = OP_OR;  gout_o = GOUT_OR;  end
      default: begin
        case (funct_i)
          FUNCT_ADD: begin op_o = OP_ADD; gout_o = GOUT_ADD; end
          FUNCT_SUB: begin op_o = OP_SUB; gout_o = GOUT_SUB; end
          FUNCT_AND: begin op_o = OP_AND; gout_o = GOUT_AND; end
          FUNCT_OR:  begin op_o = OP_OR;  gout_o = GOUT_OR;  end
          FUNCT_NOR: begin op_o = OP_NOR; gout_o = GOUT_NOR; end
          FUNCT_SLT: begin op_o = OP_SLT; gout_o = GOUT_SLT; end
          FUNCT_MULT:  op_o = mul_en_i ? OP_MULT  : OP_ILL;
          FUNCT_MULTU: op_o = mul_en_i ? OP_MULTU : OP_ILL;
          FUNCT_MFHI:  op_o = mul_en_i ? OP_MFHI  : OP_ILL;
          FUNCT_MFLO:  op_o = mul_en_i ? OP_MFLO  : OP_ILL;
          default:     op_o = OP_ILL;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_unit_mc.sv
// rtl/alu_unit_mc.sv - registered ALU control/execute unit with iterative HI/LO multiply
module alu_unit_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             err,
  output logic [2:0]       gout
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  op_e                dec_op;
  logic [2:0]         dec_gout;
  logic               accept;
  logic               is_mul;

  logic [WIDTH-1:0]   result_q;
  logic               zero_q, ovf_q, err_q;
  logic [2:0]         gout_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  // multiply datapath: acc holds {partial high, remaining multiplier bits}
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic               sign_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH-1:0]   simple_res;
  logic               simple_ovf, simple_err;
  logic [WIDTH-1:0]   b_neg, sum, diff;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               mul_sign;
  logic [WIDTH:0]     step_add;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;

  alu_dec u_dec (
    .aluop_i  (aluop),
    .funct_i  (funct),
    .mul_en_i (MUL_EN),
    .op_o     (dec_op),
    .gout_o   (dec_gout)
  );

  assign accept = valid_i && ready;
  assign is_mul = (dec_op == OP_MULT) || (dec_op == OP_MULTU);

  // single-cycle result, overflow and illegal flag for the op being offered
  always_comb begin
    b_neg      = '0 - b;
    sum        = a + b;
    diff       = a + b_neg;
    simple_res = '0;
    simple_ovf = 1'b0;
    simple_err = 1'b0;
    case (dec_op)
      OP_ADD: begin
        simple_res = sum;
        simple_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        simple_res = diff;
        simple_ovf = (a[WIDTH-1] == b_neg[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  simple_res = a & b;
      OP_OR:   simple_res = a | b;
      OP_NOR:  simple_res = ~(a | b);
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MFHI: simple_res = hi_q;
      OP_MFLO: simple_res = lo_q;
      OP_ILL:  simple_err = 1'b1;
      default: simple_res = '0;
    endcase
  end

  // operand magnitudes; the most-negative value maps to 2^(W-1), still exact unsigned
  always_comb begin
    mag_a    = (dec_op == OP_MULT && a[WIDTH-1]) ? ('0 - a) : a;
    mag_b    = (dec_op == OP_MULT && b[WIDTH-1]) ? ('0 - b) : b;
    mul_sign = (dec_op == OP_MULT) && (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  // one radix-2 shift-add step and the final sign fix-up
  always_comb begin
    step_add = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
    acc_step = {step_add, acc_q[WIDTH-1:1]};
    prod     = sign_q ? ('0 - acc_q) : acc_q;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = is_mul ? ST_MUL : ST_DONE;
        else        state_d = ST_IDLE;
      end
      ST_MUL:  state_d = (cnt_q == CW'(WIDTH - 1)) ? ST_FIX : ST_MUL;
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    done  = (state_q == ST_DONE);
  end

  // datapath registers: simple ops commit at accept, multiply iterates then commits at FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      gout_q   <= GOUT_ADD;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      gout_q <= dec_gout;
      if (is_mul) begin
        acc_q   <= {{WIDTH{1'b0}}, mag_b};
        mcand_q <= mag_a;
        sign_q  <= mul_sign;
        cnt_q   <= '0;
      end else begin
        result_q <= simple_res;
        zero_q   <= (simple_res == '0);
        ovf_q    <= simple_ovf;
        err_q    <= simple_err;
      end
    end else if (state_q == ST_MUL) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + CW'(1);
    end else if (state_q == ST_FIX) begin
      hi_q     <= prod[2*WIDTH-1:WIDTH];
      lo_q     <= prod[WIDTH-1:0];
      result_q <= prod[WIDTH-1:0];
      zero_q   <= (prod[WIDTH-1:0] == '0);
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
  assign err    = err_q;
  assign gout   = gout_q;

endmodule

// File: tb/tb_alu_unit_mc.sv
// tb/tb_alu_unit_mc.sv - directed self-checking bench for alu_unit_mc
module tb_alu_unit_mc;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] a, b;

  logic        ready, done, zero, ovf, err;
  logic [31:0] result;
  logic [2:0]  gout;

  logic        ready_nm, done_nm, zero_nm, ovf_nm, err_nm;
  logic [31:0] result_nm;
  logic [2:0]  gout_nm;

  int n_vec = 0;
  int n_err = 0;
  int nbusy;

  alu_unit_mc #(.WIDTH(32), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .aluop(aluop), .funct(funct),
    .a(a), .b(b), .ready(ready), .done(done), .result(result), .zero(zero),
    .ovf(ovf), .err(err), .gout(gout)
  );

  alu_unit_mc #(.WIDTH(32), .MUL_EN(1'b0)) u_dut_nm (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .aluop(aluop), .funct(funct),
    .a(a), .b(b), .ready(ready_nm), .done(done_nm), .result(result_nm), .zero(zero_nm),
    .ovf(ovf_nm), .err(err_nm), .gout(gout_nm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // present one request for one edge, then sample #1 after that edge
  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] av, input logic [31:0] bv);
    valid_i = 1'b1;
    aluop   = op;
    funct   = fn;
    a       = av;
    b       = bv;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic idle_cycle();
    valid_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    aluop   = 2'b00;
    funct   = 6'd0;
    a       = 32'd0;
    b       = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_ready", ready, 1'b1);
    chkb("rst_done",  done,  1'b0);
    chkb("rst_zero",  zero,  1'b1);
    chk ("rst_result", result, 32'd0);
    chk ("rst_gout", {29'd0, gout}, 32'h2);
    rst_n = 1'b1;
    idle_cycle();
    chkb("idle_ready", ready, 1'b1);

    // HI/LO cleared by reset
    issue(2'b10, 6'b010000, 32'd0, 32'd0);
    chkb("mfhi0_done", done, 1'b1);
    chk ("mfhi0", result, 32'd0);
    issue(2'b10, 6'b010010, 32'd0, 32'd0);
    chk ("mflo0", result, 32'd0);

    // back-to-back simple ops, one per cycle
    issue(2'b10, 6'b100000, 32'd7, 32'd5);
    chkb("add_done", done, 1'b1);
    chk ("add_res", result, 32'd12);
    chk ("add_gout", {29'd0, gout}, 32'h2);
    chkb("add_zero", zero, 1'b0);
    chkb("add_ovf", ovf, 1'b0);
    issue(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1);
    chk ("addov_res", result, 32'h8000_0000);
    chkb("addov_ovf", ovf, 1'b1);
    issue(2'b01, 6'b000000, 32'h1234, 32'h1234);
    chk ("sub_res", result, 32'd0);
    chkb("sub_zero", zero, 1'b1);
    chk ("sub_gout", {29'd0, gout}, 32'h6);
    chkb("sub_ovf", ovf, 1'b0);
    issue(2'b01, 6'b000000, 32'h8000_0000, 32'd1);
    chk ("subov_res", result, 32'h7FFF_FFFF);
    chkb("subov_ovf", ovf, 1'b1);
    issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
    chk ("slt_res", result, 32'd1);
    chk ("slt_gout", {29'd0, gout}, 32'h7);
    issue(2'b10, 6'b100111, 32'd0, 32'd0);
    chk ("nor_res", result, 32'hFFFF_FFFF);
    chk ("nor_gout", {29'd0, gout}, 32'h3);
    issue(2'b11, 6'b000000, 32'hF0, 32'h0F);
    chk ("ori_res", result, 32'hFF);
    issue(2'b10, 6'b100100, 32'hF0F0, 32'hFF00);
    chk ("and_res", result, 32'hF000);
    chk ("and_gout", {29'd0, gout}, 32'h0);
    issue(2'b10, 6'b111111, 32'd9, 32'd9);
    chkb("ill_err", err, 1'b1);
    chk ("ill_res", result, 32'd0);
    chk ("ill_gout", {29'd0, gout}, 32'h4);
    idle_cycle();
    chkb("idle_done", done, 1'b0);
    chkb("idle_hold_err", err, 1'b1);

    // signed multiply -3 * 5 with a request pulsed mid-flight
    issue(2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd5);
    chkb("mul_busy", ready, 1'b0);
    chkb("nm_mult_done", done_nm, 1'b1);
    chkb("nm_mult_err", err_nm, 1'b1);
    chk ("nm_mult_gout", {29'd0, gout_nm}, 32'h4);
    nbusy = 1;
    for (int i = 0; i < 100; i++) begin
      if (i == 5) begin
        valid_i = 1'b1; aluop = 2'b10; funct = 6'b100000; a = 32'd1; b = 32'd1;
      end else begin
        valid_i = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) break;
      if (!ready) nbusy++;
    end
    valid_i = 1'b0;
    chkb("mul_done", done, 1'b1);
    chk ("mul_busy_cycles", nbusy, 32'd33);
    chk ("mul_res", result, 32'hFFFF_FFF1);
    chk ("mul_gout", {29'd0, gout}, 32'h4);
    chkb("mul_err", err, 1'b0);
    issue(2'b10, 6'b010000, 32'd0, 32'd0);
    chk ("mfhi1", result, 32'hFFFF_FFFF);
    chkb("nm_mfhi_err", err_nm, 1'b1);
    issue(2'b10, 6'b010010, 32'd0, 32'd0);
    chk ("mflo1", result, 32'hFFFF_FFF1);

    // unsigned multiply
    issue(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 100 && !done; i++) begin @(posedge clk); #1; end
    chk ("multu_lo", result, 32'hFFFF_FFFE);
    issue(2'b10, 6'b010000, 32'd0, 32'd0);
    chk ("multu_hi", result, 32'd1);

    // most-negative squared
    issue(2'b10, 6'b011000, 32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 100 && !done; i++) begin @(posedge clk); #1; end
    chk ("mneg_lo", result, 32'd0);
    chkb("mneg_zero", zero, 1'b1);
    issue(2'b10, 6'b010000, 32'd0, 32'd0);
    chk ("mneg_hi", result, 32'h4000_0000);

    // reset in the middle of a multiply
    issue(2'b10, 6'b011000, 32'd3, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    chkb("rmid_busy", ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chkb("rmid_ready", ready, 1'b1);
    chkb("rmid_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) nbusy++;
    end
    chk ("rmid_no_done", nbusy, 32'd0);
    issue(2'b10, 6'b010000, 32'd0, 32'd0);
    chk ("rmid_hi", result, 32'd0);
    issue(2'b10, 6'b010010, 32'd0, 32'd0);
    chk ("rmid_lo", result, 32'd0);
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
